// File: rtl/image_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : image_ram_arb_pkg
// Description : Shared types and limits for the IMAGE_RAM arbiter slice.
//               Holds the requester/owner encoding, the default bus widths
//               and the supported READ_LATENCY range.
// Contents    : owner_t enum        {OWN_NONE, OWN_CPU, OWN_EXT}
//               ADDR_W_DEFAULT       default RAM address width
//               DATA_W_DEFAULT       default RAM data width
//               READ_LATENCY_*       default / minimum / maximum read latency
//               clamp_read_latency() folds a latency parameter into range
// Revision    : 1.0 - initial release
// ============================================================================
package image_ram_arb_pkg;

  // Owner of the RAM port for the current cycle. This is also the tag
  // carried along the read-return pipe.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  localparam int unsigned ADDR_W_DEFAULT       = 16;
  localparam int unsigned DATA_W_DEFAULT       = 8;
  localparam int unsigned READ_LATENCY_DEFAULT = 1;
  localparam int unsigned READ_LATENCY_MIN     = 1;
  localparam int unsigned READ_LATENCY_MAX     = 2;

  // Only 1- and 2-cycle RAMs exist on this platform. An out-of-range
  // parameter is folded to the nearest legal depth rather than building a
  // zero-length or oversized tag pipe.
  function automatic int unsigned clamp_read_latency(input int unsigned lat);
    if (lat < READ_LATENCY_MIN) begin
      return READ_LATENCY_MIN;
    end else if (lat > READ_LATENCY_MAX) begin
      return READ_LATENCY_MAX;
    end else begin
      return lat;
    end
  endfunction

endpackage : image_ram_arb_pkg
`default_nettype wire

// File: rtl/image_ram_arbiter_ram_read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ram_read_tag_pipe
// Description : DEPTH-stage shift register of {valid, owner} read tags. A tag
//               enters on the edge where the RAM samples a read address and
//               leaves the last stage in the cycle where RAM_Q carries that
//               read's data. Synchronous active-high reset empties the pipe.
// Ports       : clk_i        clock, rising edge
//               rst_i        synchronous reset, active high
//               tag_valid_i  a read is being issued to the RAM this cycle
//               tag_owner_i  requester that issued it
//               tag_valid_o  last stage holds a read whose data is on RAM_Q
//               tag_owner_o  requester of that read
//               any_valid_o  at least one read is still in flight
// Revision    : 1.0 - initial release
// ============================================================================
module ram_read_tag_pipe
  import image_ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   tag_valid_i,
  input  owner_t tag_owner_i,
  output logic   tag_valid_o,
  output owner_t tag_owner_o,
  output logic   any_valid_o
);

  logic [DEPTH-1:0] valid_q;
  owner_t           owner_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        owner_q[i] <= OWN_NONE;
      end
    end else begin
      valid_q[0] <= tag_valid_i;
      owner_q[0] <= tag_owner_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign tag_valid_o = valid_q[DEPTH-1];
  assign tag_owner_o = owner_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule : ram_read_tag_pipe
`default_nettype wire

// File: rtl/image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : image_ram_arbiter
// Description : Shares the single-port IMAGE_RAM between the CPU data port
//               and the EXT port (image loader / result readout). One access
//               per cycle using a req/gnt handshake; read data is routed back
//               to the requester that issued the read.
// Config      : ARB_ROUND_ROBIN_EN - when defined, simultaneous eligible
//               requests go to the requester that was not granted last.
//               When undefined, CPU has fixed priority.
// Ports       : MAIN_CLOCK / RESET        clock, synchronous active-high reset
//               CPU_REQ/WE/ADDR/WDATA     CPU request fields (held until GNT)
//               CPU_GNT                   CPU access on the RAM this cycle
//               CPU_RVALID / CPU_RDATA    CPU read return
//               EXT_*                     same set for the EXT requester
//               RAM_ADDRESS/DATA/WREN     to IMAGE_RAM
//               RAM_Q                     from IMAGE_RAM
//               BUSY                      grant active or read in flight
// Revision    : 1.0 - initial release
// ============================================================================
module image_ram_arbiter
  import image_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEFAULT
) (
  input  logic              MAIN_CLOCK,
  input  logic              RESET,
  // CPU data port
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [DATA_W-1:0] CPU_RDATA,
  // EXT port
  input  logic              EXT_REQ,
  input  logic              EXT_WE,
  input  logic [ADDR_W-1:0] EXT_ADDR,
  input  logic [DATA_W-1:0] EXT_WDATA,
  output logic              EXT_GNT,
  output logic              EXT_RVALID,
  output logic [DATA_W-1:0] EXT_RDATA,
  // IMAGE_RAM side
  output logic [ADDR_W-1:0] RAM_ADDRESS,
  output logic [DATA_W-1:0] RAM_DATA,
  output logic              RAM_WREN,
  input  logic [DATA_W-1:0] RAM_Q,
  // status
  output logic              BUSY
);

  localparam int unsigned RL_C = clamp_read_latency(READ_LATENCY);

  // Registered access: owner plus the winner's latched request fields.
  owner_t              owner_q;
  owner_t              owner_d;
  logic                wren_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  // Registered read return.
  logic                cpu_rvalid_q;
  logic                ext_rvalid_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                cpu_elig;
  logic                ext_elig;

  logic                tag_valid;
  owner_t              tag_owner;
  logic                tags_in_flight;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t              last_q;
`endif

  // A requester whose GNT is high this cycle still shows the REQ/fields of
  // the access being issued now; it may only present its next request from
  // the following edge on, so it sits out the edge that ends its GNT cycle.
  assign cpu_elig = CPU_REQ & (owner_q != OWN_CPU);
  assign ext_elig = EXT_REQ & (owner_q != OWN_EXT);

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_elig && ext_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
      owner_d = (last_q == OWN_CPU) ? OWN_EXT : OWN_CPU;
`else
      owner_d = OWN_CPU;
`endif
    end else if (cpu_elig) begin
      owner_d = OWN_CPU;
    end else if (ext_elig) begin
      owner_d = OWN_EXT;
    end
  end

  // Arbitration edge: latch the winner. With no winner, address/data hold
  // their previous values and only the write enable is dropped.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      owner_q <= OWN_NONE;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      owner_q <= owner_d;
      case (owner_d)
        OWN_CPU: begin
          wren_q <= CPU_WE;
          addr_q <= CPU_ADDR;
          data_q <= CPU_WDATA;
        end
        OWN_EXT: begin
          wren_q <= EXT_WE;
          addr_q <= EXT_ADDR;
          data_q <= EXT_WDATA;
        end
        default: begin
          wren_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // After reset the CPU is treated as "not last", so it wins the first tie.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      last_q <= OWN_EXT;
    end else if (owner_d != OWN_NONE) begin
      last_q <= owner_d;
    end
  end
`endif

  // The tag enters the pipe on the edge the RAM samples the read address
  // and emerges in the cycle where RAM_Q is valid for that read.
  ram_read_tag_pipe #(
    .DEPTH       (RL_C)
  ) u_tag_pipe (
    .clk_i       (MAIN_CLOCK),
    .rst_i       (RESET),
    .tag_valid_i ((owner_q != OWN_NONE) & ~wren_q),
    .tag_owner_i (owner_q),
    .tag_valid_o (tag_valid),
    .tag_owner_o (tag_owner),
    .any_valid_o (tags_in_flight)
  );

  // RAM_Q is captured together with the steering tag, so RVALID and RDATA
  // are clean registered outputs one cycle after the tag leaves the pipe.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      cpu_rvalid_q <= tag_valid & (tag_owner == OWN_CPU);
      ext_rvalid_q <= tag_valid & (tag_owner == OWN_EXT);
      if (tag_valid) begin
        rdata_q <= RAM_Q;
      end
    end
  end

  assign CPU_GNT     = (owner_q == OWN_CPU);
  assign EXT_GNT     = (owner_q == OWN_EXT);
  assign RAM_ADDRESS = addr_q;
  assign RAM_DATA    = data_q;
  assign RAM_WREN    = wren_q;

  // Both return buses carry the same data; only RVALID says whose it is.
  assign CPU_RVALID  = cpu_rvalid_q;
  assign EXT_RVALID  = ext_rvalid_q;
  assign CPU_RDATA   = rdata_q;
  assign EXT_RDATA   = rdata_q;

  assign BUSY        = (owner_q != OWN_NONE) | tags_in_flight;

endmodule : image_ram_arbiter
`default_nettype wire
